// File: rtl/sd_acq_event_gen.sv
// Acquisition event generator: compares the sequence counter against NUM_EVT
// double-buffered compare points and emits one-shot hits, sticky flags and a sampled code word.
module sd_acq_event_gen #(
  parameter int NUM_EVT = 8,
  parameter int CNT_W   = 22,
  parameter int BUS_W   = 16,
  parameter int STAT_W  = 4
) (
  input  logic                      clk_sys,
  input  logic                      rst,
  input  logic [CNT_W-1:0]          count,
  input  logic                      cnt_valid,
  input  logic                      cfg_load,
  input  logic [7:0]                cfg_sel,
  input  logic [BUS_W-1:0]          cfg_data,
  input  logic                      cfg_commit,
  input  logic                      dds_en,
  input  logic [STAT_W-1:0]         status_in,
  output logic [NUM_EVT-1:0]        evt_hit,
  output logic [NUM_EVT-1:0]        evt_sticky,
  output logic [NUM_EVT+STAT_W-1:0] code_out,
  output logic                      cfg_err
);

  logic [CNT_W-1:0]          sh_cmp_q  [NUM_EVT];
  logic [CNT_W-1:0]          sh_cmp_d  [NUM_EVT];
  logic [CNT_W-1:0]          act_cmp_q [NUM_EVT];
  logic [CNT_W-1:0]          act_cmp_d [NUM_EVT];
  logic [NUM_EVT-1:0]        sh_en_q, sh_en_d;
  logic [NUM_EVT-1:0]        act_en_q, act_en_d;
  logic [NUM_EVT-1:0]        armed_q, armed_d;
  logic [NUM_EVT-1:0]        hit_q, hit_d;
  logic [NUM_EVT-1:0]        sticky_q, sticky_d;
  logic [NUM_EVT-1:0]        acc_q, acc_d;
  logic [NUM_EVT+STAT_W-1:0] code_q, code_d;
  logic                      cfg_err_q, cfg_err_d;
  logic                      rearm;
  logic                      sel_ok;
  logic [NUM_EVT-1:0]        match;

  always_comb begin
    sh_cmp_d  = sh_cmp_q;
    act_cmp_d = act_cmp_q;
    sh_en_d   = sh_en_q;
    act_en_d  = act_en_q;
    match     = '0;
    sel_ok    = 1'b0;
    cfg_err_d = 1'b0;

    // A count of zero re-arms everything and counts as armed for its own compare.
    rearm = cnt_valid && (count == '0);
    for (int unsigned k = 0; k < NUM_EVT; k++)
      match[k] = cnt_valid && (count == act_cmp_q[k]) && act_en_q[k] && (armed_q[k] || rearm);

    if (cfg_load) begin
      for (int unsigned k = 0; k < NUM_EVT; k++) begin
        if (cfg_sel == 8'(2 * k)) begin
          sh_cmp_d[k][15:0] = cfg_data[15:0];
          sel_ok = 1'b1;
        end
        if (cfg_sel == 8'(2 * k + 1)) begin
          sh_cmp_d[k][CNT_W-1:16] = cfg_data[CNT_W-17:0];
          sel_ok = 1'b1;
        end
      end
      if (cfg_sel == 8'(2 * NUM_EVT)) begin
        sh_en_d = cfg_data[NUM_EVT-1:0];
        sel_ok  = 1'b1;
      end
      cfg_err_d = !sel_ok;
    end

    hit_d = match;
    // Commit takes the forwarded shadow values; its sticky clear and re-arm
    // override any hit evaluated in the same cycle.
    if (cfg_commit) begin
      act_cmp_d = sh_cmp_d;
      act_en_d  = sh_en_d;
      sticky_d  = '0;
      armed_d   = '1;
    end else begin
      sticky_d  = sticky_q | match;
      armed_d   = (armed_q | {NUM_EVT{rearm}}) & ~match;
    end

    if (dds_en) begin
      code_d = {acc_q | hit_q, status_in};
      acc_d  = '0;
    end else begin
      code_d = code_q;
      acc_d  = acc_q | hit_q;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      for (int unsigned k = 0; k < NUM_EVT; k++) begin
        sh_cmp_q[k]  <= '1;
        act_cmp_q[k] <= '1;
      end
      sh_en_q   <= '0;
      act_en_q  <= '0;
      armed_q   <= '1;
      hit_q     <= '0;
      sticky_q  <= '0;
      acc_q     <= '0;
      code_q    <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      sh_cmp_q  <= sh_cmp_d;
      act_cmp_q <= act_cmp_d;
      sh_en_q   <= sh_en_d;
      act_en_q  <= act_en_d;
      armed_q   <= armed_d;
      hit_q     <= hit_d;
      sticky_q  <= sticky_d;
      acc_q     <= acc_d;
      code_q    <= code_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign evt_hit    = hit_q;
  assign evt_sticky = sticky_q;
  assign code_out   = code_q;
  assign cfg_err    = cfg_err_q;

endmodule

// File: tb/tb_sd_acq_event_gen.sv
// Bench for sd_acq_event_gen: directed scenarios with literal expectations, then
// random traffic, all checked each cycle against an event-level reference model.
module tb_sd_acq_event_gen;
  localparam int N  = 8;
  localparam int CW = 22;
  localparam int SW = 4;

  logic              clk_sys = 1'b0;
  logic              rst = 1'b1;
  logic [CW-1:0]     count = '0;
  logic              cnt_valid = 1'b0;
  logic              cfg_load = 1'b0;
  logic [7:0]        cfg_sel = '0;
  logic [15:0]       cfg_data = '0;
  logic              cfg_commit = 1'b0;
  logic              dds_en = 1'b0;
  logic [SW-1:0]     status_in = '0;
  logic [N-1:0]      evt_hit;
  logic [N-1:0]      evt_sticky;
  logic [N+SW-1:0]   code_out;
  logic              cfg_err;

  sd_acq_event_gen #(.NUM_EVT(N), .CNT_W(CW), .BUS_W(16), .STAT_W(SW)) dut (
    .clk_sys(clk_sys), .rst(rst), .count(count), .cnt_valid(cnt_valid),
    .cfg_load(cfg_load), .cfg_sel(cfg_sel), .cfg_data(cfg_data),
    .cfg_commit(cfg_commit), .dds_en(dds_en), .status_in(status_in),
    .evt_hit(evt_hit), .evt_sticky(evt_sticky), .code_out(code_out), .cfg_err(cfg_err)
  );

  always #5 clk_sys = ~clk_sys;

  // Reference model state
  logic [CW-1:0]   m_sh [N];
  logic [CW-1:0]   m_act [N];
  logic [N-1:0]    m_sh_en, m_act_en, m_armed, m_hit, m_sticky, m_acc;
  logic [N+SW-1:0] m_code;
  logic            m_err;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;
  int hit_tot [N];
  int snap [N];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic model_step();
    logic [N-1:0] nh;
    logic [63:0]  tmp;
    bit           zero_seen;
    int           s;
    if (rst) begin
      for (int k = 0; k < N; k++) begin m_sh[k] = '1; m_act[k] = '1; end
      m_sh_en = '0; m_act_en = '0; m_armed = '1; m_hit = '0;
      m_sticky = '0; m_acc = '0; m_code = '0; m_err = 1'b0;
      return;
    end
    zero_seen = cnt_valid && (count == 0);
    nh = '0;
    for (int k = 0; k < N; k++)
      if (cnt_valid && count == m_act[k] && m_act_en[k] && (m_armed[k] || zero_seen)) nh[k] = 1'b1;
    if (dds_en) begin
      m_code = {m_acc | m_hit, status_in};
      m_acc  = '0;
    end else begin
      m_acc = m_acc | m_hit;
    end
    m_err = 1'b0;
    if (cfg_load) begin
      s = int'(cfg_sel);
      if (s < 2 * N) begin
        tmp = 64'(m_sh[s / 2]);
        if (s % 2 == 0) tmp = (tmp & ~64'hFFFF) | 64'(cfg_data);
        else            tmp = (tmp & 64'hFFFF) | (64'(cfg_data) << 16);
        m_sh[s / 2] = tmp[CW-1:0];
      end else if (s == 2 * N) begin
        m_sh_en = cfg_data[N-1:0];
      end else begin
        m_err = 1'b1;
      end
    end
    if (cfg_commit) begin
      for (int k = 0; k < N; k++) m_act[k] = m_sh[k];
      m_act_en = m_sh_en;
      m_sticky = '0;
      m_armed  = '1;
    end else begin
      m_sticky = m_sticky | nh;
      for (int k = 0; k < N; k++) begin
        if (zero_seen) m_armed[k] = 1'b1;
        if (nh[k])     m_armed[k] = 1'b0;
      end
    end
    m_hit = nh;
  endtask

  task automatic tick();
    @(negedge clk_sys);
    if (chk_en) begin
      chk("evt_hit", 64'(evt_hit), 64'(m_hit));
      chk("evt_sticky", 64'(evt_sticky), 64'(m_sticky));
      chk("code_out", 64'(code_out), 64'(m_code));
      chk("cfg_err", 64'(cfg_err), 64'(m_err));
      for (int k = 0; k < N; k++) hit_tot[k] += int'(evt_hit[k]);
    end
    @(posedge clk_sys);
    model_step();
    #1;
  endtask

  task automatic cfg_wr(input logic [7:0] sel, input logic [15:0] data);
    cfg_load = 1'b1; cfg_sel = sel; cfg_data = data;
    tick();
    cfg_load = 1'b0;
  endtask

  task automatic commit();
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
  endtask

  task automatic take_snap();
    for (int k = 0; k < N; k++) snap[k] = hit_tot[k];
  endtask

  initial begin
    for (int k = 0; k < N; k++) hit_tot[k] = 0;
    tick(); tick();
    rst = 1'b0;
    chk_en = 1'b1;
    chk("rst_hit", 64'(evt_hit), 64'h0);
    chk("rst_sticky", 64'(evt_sticky), 64'h0);
    chk("rst_code", 64'(code_out), 64'h0);
    chk("rst_err", 64'(cfg_err), 64'h0);

    // 1: single channel on a ramp
    cfg_wr(8'd0, 16'h0010); cfg_wr(8'd1, 16'h0000); cfg_wr(8'd16, 16'h0001); commit();
    take_snap();
    for (int c = 0; c <= 'h20; c++) begin
      count = CW'(c); cnt_valid = 1'b1; tick();
      chk("s1_hit", 64'(evt_hit), (c == 'h10) ? 64'h1 : 64'h0);
    end
    cnt_valid = 1'b0;
    chk("s1_sticky", 64'(evt_sticky), 64'h01);
    chk("s1_count0", 64'(hit_tot[0] - snap[0]), 64'd1);

    // 2: shadow write without commit has no effect
    cfg_wr(8'd6, 16'hABCD); cfg_wr(8'd7, 16'h0002); cfg_wr(8'd16, 16'h0008);
    for (int c = 'h2ABC8; c <= 'h2ABD2; c++) begin
      count = CW'(c); cnt_valid = 1'b1; tick();
      chk("s2_nohit", 64'(evt_hit), 64'h0);
    end
    cnt_valid = 1'b0;
    commit();
    for (int c = 'h2ABC8; c <= 'h2ABD2; c++) begin
      count = CW'(c); cnt_valid = 1'b1; tick();
      chk("s2_hit", 64'(evt_hit), (c == 'h2ABCD) ? 64'h08 : 64'h0);
    end
    cnt_valid = 1'b0;

    // 3: stall on match fires once; re-arm via count 0
    cfg_wr(8'd16, 16'h0001); commit();
    for (int i = 0; i < 5; i++) begin
      count = CW'('h10); cnt_valid = 1'b1; tick();
      chk("s3_stall", 64'(evt_hit), (i == 0) ? 64'h1 : 64'h0);
    end
    count = '0; tick();
    chk("s3_zero", 64'(evt_hit), 64'h0);
    count = CW'('h10); tick();
    chk("s3_rearm", 64'(evt_hit), 64'h1);
    cnt_valid = 1'b0;

    // 4: simultaneous channels; commit on the match cycle
    cfg_wr(8'd2, 16'h0055); cfg_wr(8'd3, 16'h0000);
    cfg_wr(8'd4, 16'h0055); cfg_wr(8'd5, 16'h0000);
    cfg_wr(8'd16, 16'h0006); commit();
    for (int c = 'h50; c <= 'h5A; c++) begin
      count = CW'(c); cnt_valid = 1'b1; tick();
      chk("s4_pair", 64'(evt_hit), (c == 'h55) ? 64'h06 : 64'h0);
    end
    count = '0; tick();
    count = CW'('h55); cfg_commit = 1'b1; tick();
    cfg_commit = 1'b0; cnt_valid = 1'b0;
    chk("s4_commit_hit", 64'(evt_hit), 64'h06);
    chk("s4_commit_sticky", 64'(evt_sticky), 64'h0);

    // 5: accumulation between strobes
    cfg_wr(8'd8, 16'h0014); cfg_wr(8'd9, 16'h0000); cfg_wr(8'd16, 16'h0011); commit();
    status_in = 4'b1010;
    for (int c = 'h0D; c <= 'h21; c++) begin
      count = CW'(c); cnt_valid = 1'b1;
      dds_en = (c == 'h0D || c == 'h17 || c == 'h21);
      tick();
      dds_en = 1'b0;
      if (c == 'h17) chk("s5_code_hits", 64'(code_out), 64'h11A);
      if (c == 'h21) chk("s5_code_empty", 64'(code_out), 64'h00A);
    end
    cnt_valid = 1'b0;

    // 6: invalid select, then reset mid-ramp dropping an in-flight pulse
    cfg_wr(8'h7F, 16'hFFFF);
    chk("s6_err", 64'(cfg_err), 64'h1);
    tick();
    chk("s6_err_end", 64'(cfg_err), 64'h0);
    commit();
    for (int c = 0; c <= 'h14; c++) begin
      count = CW'(c); cnt_valid = 1'b1; rst = (c == 'h14);
      tick();
    end
    rst = 1'b0;
    chk("s6_rst_hit", 64'(evt_hit), 64'h0);
    chk("s6_rst_sticky", 64'(evt_sticky), 64'h0);
    chk("s6_rst_code", 64'(code_out), 64'h0);
    take_snap();
    for (int c = 0; c <= 'h30; c++) begin
      count = CW'(c); tick();
    end
    cnt_valid = 1'b0;
    for (int k = 0; k < N; k++) chk("s6_quiet", 64'(hit_tot[k] - snap[k]), 64'd0);

    // Random traffic with small compare values so matches are frequent
    for (int k = 0; k < N; k++) begin
      cfg_wr(8'(2 * k), 16'($urandom_range(0, 40)));
      cfg_wr(8'(2 * k + 1), 16'h0);
    end
    cfg_wr(8'd16, 16'h00FF); commit();
    for (int i = 0; i < 3000; i++) begin
      count      = CW'($urandom_range(0, 40));
      cnt_valid  = ($urandom_range(0, 9) < 7);
      cfg_load   = ($urandom_range(0, 7) == 0);
      cfg_sel    = 8'($urandom_range(0, 18));
      cfg_data   = cfg_sel[0] ? 16'($urandom_range(0, 7) == 0) : 16'($urandom_range(0, 255));
      cfg_commit = ($urandom_range(0, 15) == 0);
      dds_en     = ($urandom_range(0, 7) == 0);
      status_in  = 4'($urandom_range(0, 15));
      rst        = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst = 1'b0; cfg_load = 1'b0; cfg_commit = 1'b0; dds_en = 1'b0; cnt_valid = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
